// File: rtl/selector_frecuencias_if.sv
// selector_frecuencias_if: button inputs (Btn_up, Btn_down) and select outputs (Selector, Step_pulse, At_max_freq, At_min_freq)
interface selector_frecuencias_if;
  logic Btn_up;
  logic Btn_down;
  logic [2:0] Selector;
  logic Step_pulse;
  logic At_max_freq;
  logic At_min_freq;
  modport master (
    output Btn_up, Btn_down,
    input Selector, Step_pulse, At_max_freq, At_min_freq
  );
  modport slave (
    input Btn_up, Btn_down,
    output Selector, Step_pulse, At_max_freq, At_min_freq
  );
endinterface

// File: rtl/selector_frecuencias.sv
// selector_frecuencias: syncs/debounces bus.Btn_up/Btn_down, auto-repeats while held, steps saturating bus.Selector with Step_pulse and limit flags; Clk, async active-low Reset_n
module selector_frecuencias #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter logic [2:0] RESET_SEL = 3'b111
) (
  input logic Clk,
  input logic Reset_n,
  selector_frecuencias_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  logic [1:0] raw, evt;
  logic [2:0] nxt;
  logic dec, inc;
  assign raw = {bus.Btn_down, bus.Btn_up};
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic meta, sync, stable, stable_d, phase, rep;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    // rcnt is 0 in the press cycle, so the first repeat lands REPEAT_DELAY edges after the press step;
    // reloading to 1 on each repeat makes later ones REPEAT_PERIOD edges apart
    always_comb rep = REPEAT_DELAY != 0 && stable && rcnt == (phase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY));
    assign evt[i] = (stable && !stable_d) || rep;
    always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
        meta <= 1'b0;
        sync <= 1'b0;
        stable <= 1'b0;
        stable_d <= 1'b0;
        dcnt <= '0;
        rcnt <= '0;
        phase <= 1'b0;
      end else begin
        meta <= raw[i];
        sync <= meta;
        stable_d <= stable;
        dcnt <= (sync != stable && dcnt != DW'(DEBOUNCE_CYCLES - 1)) ? dcnt + 1'b1 : '0;
        stable <= (sync != stable && dcnt == DW'(DEBOUNCE_CYCLES - 1)) ? sync : stable;
        rcnt <= (!stable || REPEAT_DELAY == 0) ? '0 : rep ? RW'(1) : rcnt + 1'b1;
        phase <= stable && (phase || rep);
      end
  end
  always_comb begin
    dec = evt[0] && !evt[1] && bus.Selector != 3'b000;
    inc = evt[1] && !evt[0] && bus.Selector != 3'b111;
    nxt = dec ? bus.Selector - 3'd1 : inc ? bus.Selector + 3'd1 : bus.Selector;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      bus.Selector <= RESET_SEL;
      bus.Step_pulse <= 1'b0;
      bus.At_max_freq <= RESET_SEL == 3'b000;
      bus.At_min_freq <= RESET_SEL == 3'b111;
    end else begin
      bus.Selector <= nxt;
      bus.Step_pulse <= dec || inc;
      bus.At_max_freq <= nxt == 3'b000;
      bus.At_min_freq <= nxt == 3'b111;
    end
endmodule

// File: tb/tb_selector_frecuencias.sv
// tb_selector_frecuencias: scoreboard bench, expected steps queued at stimulus time and checked by a monitor on each Step_pulse
module tb_selector_frecuencias;
  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [2:0] sel;
    int cyc;
  } exp_t;
  exp_t q[$];
  selector_frecuencias_if bus();
  selector_frecuencias #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8),
    .RESET_SEL(3'b111)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask
  task automatic tap(input bit up, input bit dn, input int exp_sel);
    if (exp_sel >= 0) q.push_back('{3'(exp_sel), cyc + 7});
    bus.Btn_up = up;
    bus.Btn_down = dn;
    cycles(10);
    bus.Btn_up = 1'b0;
    bus.Btn_down = 1'b0;
    cycles(12);
  endtask
  always @(negedge Clk)
    if (bus.Step_pulse === 1'b1) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_step cyc=%0d sel=%0d", cyc, bus.Selector);
      end else begin
        e = q.pop_front();
        if (bus.Selector !== e.sel || cyc != e.cyc || bus.At_max_freq !== (e.sel == 3'd0) || bus.At_min_freq !== (e.sel == 3'd7)) begin
          bad++;
          $display("FAIL step got sel=%0d cyc=%0d max=%b min=%b want sel=%0d cyc=%0d", bus.Selector, cyc, bus.At_max_freq, bus.At_min_freq, e.sel, e.cyc);
        end
      end
    end
  initial begin
    int n;
    bus.Btn_up = 1'b0;
    bus.Btn_down = 1'b0;
    #1 Reset_n = 1'b0;
    #1;
    chk("async_reset_sel", bus.Selector, 7);
    chk("async_reset_step", bus.Step_pulse, 0);
    cycles(3);
    Reset_n = 1'b1;
    cycles(2);
    chk("reset_sel", bus.Selector, 7);
    chk("reset_min", bus.At_min_freq, 1);
    chk("reset_max", bus.At_max_freq, 0);
    chk("reset_step", bus.Step_pulse, 0);
    tap(1, 0, 6);
    chk("single_sel", bus.Selector, 6);
    bus.Btn_down = 1'b1;
    cycles(3);
    bus.Btn_down = 1'b0;
    cycles(2);
    for (int k = 0; k < 2; k++) begin
      bus.Btn_down = 1'b1;
      cycles(2);
      bus.Btn_down = 1'b0;
      cycles(2);
    end
    cycles(10);
    chk("glitch_sel", bus.Selector, 6);
    Reset_n = 1'b0;
    cycles(2);
    Reset_n = 1'b1;
    cycles(3);
    chk("pre_repeat_sel", bus.Selector, 7);
    n = cyc;
    for (int k = 0; k < 7; k++) q.push_back('{3'(6 - k), n + (k == 0 ? 7 : 19 + 8 * k)});
    bus.Btn_up = 1'b1;
    cycles(100);
    chk("sat_sel", bus.Selector, 0);
    chk("sat_max", bus.At_max_freq, 1);
    chk("sat_min", bus.At_min_freq, 0);
    bus.Btn_up = 1'b0;
    cycles(12);
    tap(1, 0, -1);
    chk("up_at_limit_sel", bus.Selector, 0);
    for (int k = 1; k <= 4; k++) tap(0, 1, k);
    chk("pre_simul_sel", bus.Selector, 4);
    tap(1, 1, -1);
    chk("simul_sel", bus.Selector, 4);
    tap(0, 1, 5);
    chk("after_simul_sel", bus.Selector, 5);
    n = cyc;
    q.push_back('{3'd6, n + 7});
    q.push_back('{3'd7, n + 27});
    bus.Btn_down = 1'b1;
    cycles(30);
    Reset_n = 1'b0;
    #1;
    chk("rst_hold_sel", bus.Selector, 7);
    chk("rst_hold_min", bus.At_min_freq, 1);
    cycles(2);
    Reset_n = 1'b1;
    cycles(40);
    chk("post_rst_hold_sel", bus.Selector, 7);
    bus.Btn_down = 1'b0;
    cycles(12);
    q.push_back('{3'd6, cyc + 7});
    bus.Btn_up = 1'b1;
    cycles(12);
    Reset_n = 1'b0;
    cycles(2);
    Reset_n = 1'b1;
    q.push_back('{3'd6, cyc + 7});
    cycles(12);
    bus.Btn_up = 1'b0;
    cycles(12);
    chk("requalify_sel", bus.Selector, 6);
    cycles(5);
    chk("pending_steps", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/selector_frecuencias.md
# selector_frecuencias

Push-button driven frequency-range selector that generates the 3-bit select word for the switching-frequency multiplexer. It synchronizes and debounces two raw buttons, detects presses, applies optional auto-repeat while a button is held, and steps a saturating 3-bit register. It sits directly upstream of the frequency mux: `Selector` from this block drives the mux select input, where 000 picks the highest frequency (200 kHz) and 111 picks the lowest (1.56 kHz).

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a button level change; minimum 1.
- `REPEAT_DELAY`, 25000000: cycles from an accepted press to the first auto-repeat step; 0 disables auto-repeat.
- `REPEAT_PERIOD`, 10000000: cycles between subsequent auto-repeat steps; minimum 1.
- `RESET_SEL`, 3'b111: value loaded into `Selector` on reset.
- `Clk` input 1: system clock; all state changes on its rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Btn_up` input 1: raw, asynchronous, active-high; raises frequency by decrementing `Selector`.
- `Btn_down` input 1: raw, asynchronous, active-high; lowers frequency by incrementing `Selector`.
- `Selector` output 3: registered select word for the frequency mux.
- `Step_pulse` output 1: one-cycle strobe, high in the cycle in which `Selector` takes a new value.
- `At_max_freq` output 1: registered; high when `Selector` == 000.
- `At_min_freq` output 1: registered; high when `Selector` == 111.

## Operation
- **Reset.** While `Reset_n` = 0, all state clears immediately:
  - `Selector` = `RESET_SEL`, `Step_pulse` = 0.
  - `At_max_freq` and `At_min_freq` reflect `RESET_SEL`; with the default they are 0 and 1.
  - Synchronizers, stable levels, debounce counters and repeat counters all clear to 0.
- **Synchronizer.** Each button passes through a 2-flop synchronizer; `sync` is the second flop.
- **Debounce** (per button): one counter and one `stable` level.
  - A cycle with `sync` ≠ `stable` increments the counter.
  - When the counter would reach `DEBOUNCE_CYCLES`, `stable` takes `sync` and the counter clears.
  - Any cycle with `sync` == `stable` clears the counter.
  - Glitches shorter than `DEBOUNCE_CYCLES` are therefore never seen.
- **Press event.** A press event is `stable` rising, detected against a one-cycle-delayed copy of `stable`.
- **Auto-repeat** (per button, only when `REPEAT_DELAY` ≠ 0):
  - The repeat counter runs while `stable` = 1.
  - It emits a repeat event `REPEAT_DELAY` cycles after the press event, then every `REPEAT_PERIOD` cycles.
  - `stable` = 0 clears the counter and its phase.
- **Step** (up_evt and down_evt are press or repeat events, resolved per cycle):
  - up_evt only, with `Selector` ≠ 000: `Selector` decrements.
  - down_evt only, with `Selector` ≠ 111: `Selector` increments.
  - Both in the same cycle: no change. They cancel.
  - Request at a limit (up at 000, down at 111): no change, no `Step_pulse`. Never wraps.
- **Held buttons.** Holding one button does not block the other; their events are evaluated independently each cycle.
- **Flags.** `Step_pulse` is asserted only when `Selector` actually changes value. `At_max_freq` and `At_min_freq` update in the same edge as `Selector`.

## Timing
- **Press latency.** Let a raw rising button edge be first sampled at clock edge 1. Then:
  - `sync` is valid after edge 2.
  - `stable` rises at edge 2+`DEBOUNCE_CYCLES`.
  - `Selector` and `Step_pulse` update at edge 3+`DEBOUNCE_CYCLES`.
  - Total latency is `DEBOUNCE_CYCLES`+3 edges.
- **Release.** Release latency to `stable` low is `DEBOUNCE_CYCLES`+2 edges. Release produces no step.
- **Repeat spacing.** The first repeat step occurs `REPEAT_DELAY` edges after the press step, and subsequent steps every `REPEAT_PERIOD` edges.
- **Step strobe.** `Step_pulse` is exactly 1 cycle wide. Consecutive steps are at least 1 idle cycle apart whenever `REPEAT_PERIOD` ≥ 2.
- **Reset mid-operation.** Reset takes effect asynchronously in the middle of a debounce or repeat interval. After deassertion, a button still held must re-qualify for a full `DEBOUNCE_CYCLES` before it produces a press event. A held button therefore gets one new step after reset, not an immediate one.
- **Reset release.** `Reset_n` deassertion is assumed synchronous to `Clk` at system level. No step may occur in the first 2 cycles after release.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8, `RESET_SEL`=111.

- **Reset state.** Assert `Reset_n`=0, then release -> `Selector`=111, `At_min_freq`=1, `At_max_freq`=0, `Step_pulse`=0.
- **Single press, exact latency.** Clean `Btn_up` press held 10 cycles -> exactly one `Step_pulse`, 7 edges after first sample; `Selector` 111->110.
- **Glitch rejection.** `Btn_down` pulse of 3 cycles, then bounce 1/0/1/0 at 2-cycle spacing -> no `Step_pulse`, `Selector` unchanged.
- **Auto-repeat to saturation.** Hold `Btn_up` from `Selector`=111 for 100 cycles:
  - Steps occur at press+0, +20, +28, +36, … down to 000.
  - Once at 000, `At_max_freq`=1 and no further `Step_pulse` occurs.
- **Simultaneous press.** `Btn_up` and `Btn_down` rise in the same cycle from `Selector`=100 -> no change, no `Step_pulse`. Releasing both then pressing `Btn_down` alone -> 101.
- **Reset during hold.** Hold `Btn_down` and pulse `Reset_n` low mid-repeat -> `Selector` returns to 111 immediately, and no step occurs after release, because the button is already at the 111 limit.
